// File: rtl/usb_tx_line_encoder_pkg.sv
// Shared types and constants for the USB FS/LS transmit line encoder.
// Line-state to pin mapping lives here so every user agrees on J/K polarity.
package usb_tx_line_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    ABORT,
    EOP_SE0,
    EOP_J
  } usb_tx_state_t;

  typedef enum logic [1:0] {
    LINE_SE0,
    LINE_J,
    LINE_K
  } lineState_t;

  // Shifted out LSB first, so the wire sees 0000_0001.
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  // Returns {dp, dn}; low speed swaps the J and K polarities, SE0 is unaffected.
  function automatic logic [1:0] linePins(lineState_t line, logic lowSpeed);
    logic [1:0] pins;
    pins = 2'b00;
    case (line)
      LINE_J:  pins = lowSpeed ? 2'b01 : 2'b10;
      LINE_K:  pins = lowSpeed ? 2'b10 : 2'b01;
      default: pins = 2'b00;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI level register plus consecutive-ones counter with stuff-bit insertion.
// A bypassed bit is encoded but never stuffed and restarts the ones count.
module usb_nrzi_stuffer
  import usb_tx_line_encoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bitValid,
  input  logic bitIn,
  input  logic bypassStuff,
  output logic stall,
  output logic stuffDueNext,
  output logic levelKNext
);

  logic       levelK;
  logic [2:0] onesCnt;
  logic [2:0] onesCntNext;
  logic       effBit;

  always_comb begin
    stall       = bitValid && !bypassStuff && (onesCnt == STUFF_LIMIT);
    effBit      = bitIn && !stall;
    levelKNext  = levelK;
    onesCntNext = onesCnt;
    if (bitValid) begin
      if (!effBit) levelKNext = !levelK;
      if (bypassStuff || !effBit) onesCntNext = '0;
      else onesCntNext = onesCnt + 3'd1;
    end else if (clear) begin
      levelKNext  = 1'b0;
      onesCntNext = '0;
    end
    stuffDueNext = (onesCntNext == STUFF_LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      levelK  <= 1'b0;
      onesCnt <= '0;
    end else begin
      levelK  <= levelKNext;
      onesCnt <= onesCntNext;
    end
  end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB FS/LS transmit path: byte handshake in, SYNC + stuffed NRZI data + EOP out.
// Every cycle decides the line state for the next cycle; all pins are registered.
//
// state   | meaning
// IDLE    | line J, OE low; a request emits the first SYNC bit
// SYNC    | SYNC bits 1..7; the last one loads the shifter
// DATA    | shifter bits (or stuff bits) through NRZI
// ABORT   | underrun: ABORT_ONES unstuffed ones, line held
// EOP_SE0 | EOP_SE0_BITS cycles of SE0
// EOP_J   | one J bit, then IDLE
module usb_tx_line_encoder
  import usb_tx_line_encoder_pkg::*;
#(
  parameter bit LOW_SPEED    = 1'b0,
  parameter int EOP_SE0_BITS = 2,
  parameter int ABORT_ONES   = 8
) (
  input  logic       CLK12,
  input  logic       txRST,
  input  logic       txReqSendPacket,
  output logic       txAcceptNewData,
  input  logic       txDataValid,
  input  logic       txIsLastByte,
  input  logic [7:0] txData,
  output logic       sending,
  output logic       txAborted,
  output logic       USB_DP,
  output logic       USB_DN,
  output logic       USB_OE
);

  usb_tx_state_t state, stateNext;
  logic [2:0] syncCnt, syncCntNext;
  logic [2:0] bitCnt, bitCntNext;
  logic [7:0] shiftReg, shiftRegNext;
  logic       shiftValid, shiftValidNext;
  logic [3:0] abortCnt, abortCntNext;
  logic [1:0] eopCnt, eopCntNext;
  logic [7:0] holdData;
  logic       holdFull, lastSeen;

  logic       accept, byteAvail, load;
  logic [7:0] loadData;
  logic       bitValid, bitIn, bypassStuff, clearLine, useLevel;
  logic       stall, stuffDueNext, levelKNext;
  lineState_t lineNext;
  logic       oeNext;

  assign txAcceptNewData = ((state == SYNC) || (state == DATA)) && !holdFull && !lastSeen;
  assign accept          = txAcceptNewData && txDataValid;
  // A byte arriving on the very cycle the shifter needs one goes straight through.
  assign byteAvail       = holdFull || accept;
  assign loadData        = holdFull ? holdData : txData;

  usb_nrzi_stuffer u_stuffer (
    .clk         (CLK12),
    .rst         (txRST),
    .clear       (clearLine),
    .bitValid    (bitValid),
    .bitIn       (bitIn),
    .bypassStuff (bypassStuff),
    .stall       (stall),
    .stuffDueNext(stuffDueNext),
    .levelKNext  (levelKNext)
  );

  always_comb begin
    stateNext      = state;
    syncCntNext    = '0;
    bitCntNext     = bitCnt;
    shiftRegNext   = shiftReg;
    shiftValidNext = shiftValid;
    abortCntNext   = '0;
    eopCntNext     = '0;
    bitValid       = 1'b0;
    bitIn          = 1'b0;
    bypassStuff    = 1'b0;
    clearLine      = 1'b0;
    useLevel       = 1'b0;
    load           = 1'b0;
    lineNext       = LINE_J;
    oeNext         = 1'b1;

    case (state)
      IDLE: begin
        oeNext    = 1'b0;
        clearLine = 1'b1;
        if (txReqSendPacket) begin
          oeNext      = 1'b1;
          bitValid    = 1'b1;
          bitIn       = SYNC_PATTERN[0];
          useLevel    = 1'b1;
          syncCntNext = 3'd1;
          stateNext   = SYNC;
        end
      end
      SYNC: begin
        bitValid    = 1'b1;
        bitIn       = SYNC_PATTERN[syncCnt];
        useLevel    = 1'b1;
        syncCntNext = syncCnt + 3'd1;
        if (syncCnt == 3'd7) begin
          if (byteAvail) begin
            load      = 1'b1;
            stateNext = DATA;
          end else begin
            stateNext = ABORT;
          end
        end
      end
      DATA: begin
        bitValid = 1'b1;
        bitIn    = shiftValid & shiftReg[0];
        useLevel = 1'b1;
        if (!shiftValid) begin
          // Only reached to send a stuff bit owed after the final data bit.
          stateNext = EOP_SE0;
        end else if (!stall) begin
          shiftRegNext = {1'b0, shiftReg[7:1]};
          bitCntNext   = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            if (byteAvail) begin
              load = 1'b1;
            end else if (lastSeen) begin
              shiftValidNext = 1'b0;
              if (!stuffDueNext) stateNext = EOP_SE0;
            end else begin
              stateNext = ABORT;
            end
          end
        end
      end
      ABORT: begin
        bitValid     = 1'b1;
        bitIn        = 1'b1;
        bypassStuff  = 1'b1;
        useLevel     = 1'b1;
        abortCntNext = abortCnt + 4'd1;
        if (abortCnt == 4'(ABORT_ONES - 1)) stateNext = EOP_SE0;
      end
      EOP_SE0: begin
        clearLine  = 1'b1;
        lineNext   = LINE_SE0;
        eopCntNext = eopCnt + 2'd1;
        if (eopCnt == 2'(EOP_SE0_BITS - 1)) stateNext = EOP_J;
      end
      EOP_J: begin
        clearLine = 1'b1;
        lineNext  = LINE_J;
        stateNext = IDLE;
      end
      default: begin
        oeNext    = 1'b0;
        stateNext = IDLE;
      end
    endcase

    if (load) begin
      shiftRegNext   = loadData;
      shiftValidNext = 1'b1;
      bitCntNext     = '0;
    end
    if (useLevel) lineNext = levelKNext ? LINE_K : LINE_J;
  end

  always_ff @(posedge CLK12 or posedge txRST) begin
    if (txRST) begin
      state      <= IDLE;
      syncCnt    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      shiftValid <= 1'b0;
      abortCnt   <= '0;
      eopCnt     <= '0;
    end else begin
      state      <= stateNext;
      syncCnt    <= syncCntNext;
      bitCnt     <= bitCntNext;
      shiftReg   <= shiftRegNext;
      shiftValid <= shiftValidNext;
      abortCnt   <= abortCntNext;
      eopCnt     <= eopCntNext;
    end
  end

  always_ff @(posedge CLK12 or posedge txRST) begin
    if (txRST) begin
      holdData <= '0;
      holdFull <= 1'b0;
      lastSeen <= 1'b0;
    end else if (state == IDLE) begin
      holdFull <= 1'b0;
      lastSeen <= 1'b0;
    end else begin
      if (accept) lastSeen <= txIsLastByte;
      if (accept && !load) begin
        holdFull <= 1'b1;
        holdData <= txData;
      end else if (load) begin
        holdFull <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK12 or posedge txRST) begin
    if (txRST) begin
      {USB_DP, USB_DN} <= linePins(LINE_J, LOW_SPEED);
      USB_OE           <= 1'b0;
      sending          <= 1'b0;
      txAborted        <= 1'b0;
    end else begin
      {USB_DP, USB_DN} <= linePins(lineNext, LOW_SPEED);
      USB_OE           <= oeNext;
      sending          <= oeNext;
      txAborted        <= (state == ABORT) && (abortCnt == 4'd0);
    end
  end

endmodule
